// File: rtl/hood_pkg.sv
// hood_pkg: FSM state encoding and mode-code helpers shared by the range-hood controller.
package hood_pkg;

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_STANDBY   = 3'd1,
    ST_MENU      = 3'd2,
    ST_SPEED     = 3'd3,
    ST_TURBO     = 3'd4,
    ST_EXIT_WAIT = 3'd5,
    ST_CLEAN     = 3'd6
  } hood_state_e;

  localparam int MODE_STANDBY = 0;

  // Clean is reported one code above the highest (turbo) speed.
  function automatic int mode_clean(input int n_speed);
    return n_speed + 1;
  endfunction

endpackage

// File: rtl/hood_sec_timer.sv
// hood_sec_timer: loadable seconds down-counter; expire_o flags the tick that takes it from 1 to 0.
module hood_sec_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         tick_i,
  output logic [W-1:0] value_o,
  output logic         expire_o
);

  logic [W-1:0] value_q, value_d;

  // Next count: a load beats a tick; the counter parks at zero.
  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = load_val_i;
    end else if (tick_i && (value_q != {W{1'b0}})) begin
      value_d = value_q - W'(1);
    end else begin
      value_d = value_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= {W{1'b0}};
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o  = value_q;
  assign expire_o = tick_i && (value_q == W'(1));

endmodule

// File: rtl/hood_mode_ctrl.sv
// hood_mode_ctrl: range-hood power/mode FSM with per-mode countdown and cumulative run time.
// Defining HOOD_AUTO_OFF_EN adds an idle auto-off (IDLE_SEC) in STANDBY and MENU.
module hood_mode_ctrl
  import hood_pkg::*;
#(
  parameter int N_SPEED    = 3,
  parameter int TURBO_SEC  = 60,
  parameter int EXIT_SEC   = 60,
  parameter int CLEAN_SEC  = 180,
  parameter int REMIND_SEC = 36000,
  parameter int RUN_W      = 20,
  parameter int CNT_W      = 8
`ifdef HOOD_AUTO_OFF_EN
  ,
  parameter int IDLE_SEC   = 30
`endif
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            tick_1hz,
  input  logic                            power_btn,
  input  logic                            menu_btn,
  input  logic [N_SPEED-1:0]              mode_btn,
  input  logic                            clean_btn,
  output logic                            power_on,
  output logic [$clog2(N_SPEED+2)-1:0]    mode_state,
  output logic [CNT_W-1:0]                countdown,
  output logic [RUN_W-1:0]                run_time,
  output logic                            turbo_avail,
  output logic                            clean_remind
);

  localparam int MW = $clog2(N_SPEED + 2);

  hood_state_e      state_q, state_d;
  logic [MW-1:0]    speed_q, speed_d;
  logic [MW-1:0]    mode_state_q, mode_state_d;
  logic             power_on_q, power_on_d;
  logic [RUN_W-1:0] run_time_q, run_time_d;
  logic             turbo_avail_q, turbo_avail_d;
  logic             clean_remind_q, clean_remind_d;

  logic             ev_power_s, ev_menu_s, ev_clean_s, ev_mode_s, any_btn_s;
  logic [MW-1:0]    sel_speed_s;
  logic             sel_turbo_s;
  logic             cd_load_s, cd_exp_s;
  logic [CNT_W-1:0] cd_val_s, cd_value_s;
  logic             idle_exp_s, clear_run_s, fan_on_s;

  // Resolve simultaneous pulses to one winning event; lowest mode bit wins.
  always_comb begin
    any_btn_s   = power_btn | menu_btn | clean_btn | (|mode_btn);
    ev_power_s  = power_btn;
    ev_menu_s   = ~power_btn & menu_btn;
    ev_clean_s  = ~power_btn & ~menu_btn & clean_btn;
    ev_mode_s   = ~power_btn & ~menu_btn & ~clean_btn & (|mode_btn);
    sel_speed_s = {MW{1'b0}};
    for (int k = N_SPEED - 1; k >= 0; k--) begin
      if (mode_btn[k]) begin
        sel_speed_s = MW'(k + 1);
      end else begin
        sel_speed_s = sel_speed_s;
      end
    end
    sel_turbo_s = (sel_speed_s == MW'(N_SPEED));
  end

  // Next-state decode; button events outrank countdown expiry.
  always_comb begin
    state_d       = state_q;
    speed_d       = speed_q;
    turbo_avail_d = turbo_avail_q;
    cd_load_s     = 1'b0;
    cd_val_s      = {CNT_W{1'b0}};
    clear_run_s   = 1'b0;
    if (ev_power_s) begin
      cd_load_s = 1'b1;
      if (state_q == ST_OFF) begin
        state_d       = ST_STANDBY;
        turbo_avail_d = 1'b1;
      end else begin
        state_d = ST_OFF;
      end
    end else begin
      case (state_q)
        ST_STANDBY: begin
          if (ev_menu_s) begin
            state_d = ST_MENU;
          end else if (idle_exp_s && !any_btn_s) begin
            state_d = ST_OFF;
          end else begin
            state_d = ST_STANDBY;
          end
        end
        ST_MENU, ST_SPEED: begin
          if (ev_menu_s) begin
            state_d = ST_STANDBY;
          end else if (ev_clean_s && (state_q == ST_MENU)) begin
            state_d   = ST_CLEAN;
            cd_load_s = 1'b1;
            cd_val_s  = CNT_W'(CLEAN_SEC);
          end else if (ev_mode_s && sel_turbo_s) begin
            if (turbo_avail_q) begin
              state_d       = ST_TURBO;
              cd_load_s     = 1'b1;
              cd_val_s      = CNT_W'(TURBO_SEC);
              turbo_avail_d = 1'b0;
            end else begin
              state_d = state_q;
            end
          end else if (ev_mode_s) begin
            state_d = ST_SPEED;
            speed_d = sel_speed_s;
          end else if ((state_q == ST_MENU) && idle_exp_s && !any_btn_s) begin
            state_d = ST_OFF;
          end else begin
            state_d = state_q;
          end
        end
        ST_TURBO: begin
          if (ev_menu_s) begin
            state_d   = ST_EXIT_WAIT;
            cd_load_s = 1'b1;
            cd_val_s  = CNT_W'(EXIT_SEC);
          end else if (cd_exp_s) begin
            if (N_SPEED > 1) begin
              state_d = ST_SPEED;
              speed_d = MW'(N_SPEED - 1);
            end else begin
              state_d = ST_STANDBY;
            end
          end else begin
            state_d = ST_TURBO;
          end
        end
        ST_EXIT_WAIT: begin
          if (cd_exp_s) begin
            state_d = ST_STANDBY;
          end else begin
            state_d = ST_EXIT_WAIT;
          end
        end
        ST_CLEAN: begin
          if (cd_exp_s) begin
            state_d     = ST_STANDBY;
            clear_run_s = 1'b1;
          end else begin
            state_d = ST_CLEAN;
          end
        end
        ST_OFF:  state_d = ST_OFF;
        default: state_d = ST_OFF;
      endcase
    end
  end

  // Output next values derived from the next state so outputs move with it.
  always_comb begin
    power_on_d = (state_d != ST_OFF);
    case (state_d)
      ST_SPEED:     mode_state_d = speed_d;
      ST_TURBO:     mode_state_d = MW'(N_SPEED);
      ST_EXIT_WAIT: mode_state_d = MW'(N_SPEED - 1);
      ST_CLEAN:     mode_state_d = MW'(mode_clean(N_SPEED));
      default:      mode_state_d = MW'(MODE_STANDBY);
    endcase
    fan_on_s = (mode_state_q != MW'(MODE_STANDBY)) && (mode_state_q <= MW'(N_SPEED));
    if (clear_run_s) begin
      run_time_d = {RUN_W{1'b0}};
    end else if (tick_1hz && fan_on_s && (run_time_q != {RUN_W{1'b1}})) begin
      run_time_d = run_time_q + RUN_W'(1);
    end else begin
      run_time_d = run_time_q;
    end
    clean_remind_d = (run_time_d >= RUN_W'(REMIND_SEC));
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_OFF;
      speed_q        <= {MW{1'b0}};
      mode_state_q   <= {MW{1'b0}};
      power_on_q     <= 1'b0;
      run_time_q     <= {RUN_W{1'b0}};
      turbo_avail_q  <= 1'b1;
      clean_remind_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      speed_q        <= speed_d;
      mode_state_q   <= mode_state_d;
      power_on_q     <= power_on_d;
      run_time_q     <= run_time_d;
      turbo_avail_q  <= turbo_avail_d;
      clean_remind_q <= clean_remind_d;
    end
  end

  hood_sec_timer #(.W(CNT_W)) u_cd_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cd_load_s),
    .load_val_i (cd_val_s),
    .tick_i     (tick_1hz),
    .value_o    (cd_value_s),
    .expire_o   (cd_exp_s)
  );

`ifdef HOOD_AUTO_OFF_EN
  localparam int IW = $clog2(IDLE_SEC + 1);
  logic          idle_load_s;
  logic [IW-1:0] idle_value_s;

  // Idle timer is held full outside STANDBY/MENU and on any button pulse.
  assign idle_load_s = ((state_q != ST_STANDBY) && (state_q != ST_MENU)) || any_btn_s;

  hood_sec_timer #(.W(IW)) u_idle_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (idle_load_s),
    .load_val_i (IW'(IDLE_SEC)),
    .tick_i     (tick_1hz),
    .value_o    (idle_value_s),
    .expire_o   (idle_exp_s)
  );
`else
  assign idle_exp_s = 1'b0;
`endif

  assign power_on     = power_on_q;
  assign mode_state   = mode_state_q;
  assign countdown    = cd_value_s;
  assign run_time     = run_time_q;
  assign turbo_avail  = turbo_avail_q;
  assign clean_remind = clean_remind_q;

endmodule

// File: tb/tb_hood_mode_ctrl.sv
// tb_hood_mode_ctrl: directed scoreboard bench for hood_mode_ctrl at default parameters.
module tb_hood_mode_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick_1hz, power_btn, menu_btn, clean_btn;
  logic [2:0]  mode_btn;
  logic        power_on, turbo_avail, clean_remind;
  logic [2:0]  mode_state;
  logic [7:0]  countdown;
  logic [19:0] run_time;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       tag;
    logic        pw;
    logic [2:0]  ms;
    logic [7:0]  cd;
    logic [19:0] rt;
    logic        ta;
    logic        cr;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  hood_mode_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_1hz     (tick_1hz),
    .power_btn    (power_btn),
    .menu_btn     (menu_btn),
    .mode_btn     (mode_btn),
    .clean_btn    (clean_btn),
    .power_on     (power_on),
    .mode_state   (mode_state),
    .countdown    (countdown),
    .run_time     (run_time),
    .turbo_avail  (turbo_avail),
    .clean_remind (clean_remind)
  );

  task automatic cyc(input logic pb, input logic mb, input logic [2:0] md, input logic cb, input logic tk);
    power_btn = pb; menu_btn = mb; mode_btn = md; clean_btn = cb; tick_1hz = tk;
    @(posedge clk);
    #1;
    power_btn = 1'b0; menu_btn = 1'b0; mode_btn = 3'b000; clean_btn = 1'b0; tick_1hz = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b1);
  endtask

  task automatic push(input string tag, input logic pw, input logic [2:0] ms, input logic [7:0] cd,
                      input logic [19:0] rt, input logic ta, input logic cr);
    exp_t e;
    e.tag = tag; e.pw = pw; e.ms = ms; e.cd = cd; e.rt = rt; e.ta = ta; e.cr = cr;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL scoreboard_empty observed=0 entries expected=1 entry");
    end else begin
      e = sb.pop_front();
      n_cmp += 6;
      assert (power_on === e.pw) else begin
        n_bad++; $error("FAIL %s.power_on observed=%0d expected=%0d", e.tag, power_on, e.pw);
      end
      assert (mode_state === e.ms) else begin
        n_bad++; $error("FAIL %s.mode_state observed=%0d expected=%0d", e.tag, mode_state, e.ms);
      end
      assert (countdown === e.cd) else begin
        n_bad++; $error("FAIL %s.countdown observed=%0d expected=%0d", e.tag, countdown, e.cd);
      end
      assert (run_time === e.rt) else begin
        n_bad++; $error("FAIL %s.run_time observed=%0d expected=%0d", e.tag, run_time, e.rt);
      end
      assert (turbo_avail === e.ta) else begin
        n_bad++; $error("FAIL %s.turbo_avail observed=%0d expected=%0d", e.tag, turbo_avail, e.ta);
      end
      assert (clean_remind === e.cr) else begin
        n_bad++; $error("FAIL %s.clean_remind observed=%0d expected=%0d", e.tag, clean_remind, e.cr);
      end
    end
  endtask

  // One directed step: queue the expected outputs, apply the inputs for a cycle, then compare.
  task automatic step(input string tag, input logic pb, input logic mb, input logic [2:0] md, input logic cb,
                      input logic tk, input logic pw, input logic [2:0] ms, input logic [7:0] cd,
                      input logic [19:0] rt, input logic ta, input logic cr);
    push(tag, pw, ms, cd, rt, ta, cr);
    cyc(pb, mb, md, cb, tk);
    pop_check();
  endtask

  initial begin
    rst_n = 1'b0;
    power_btn = 1'b0; menu_btn = 1'b0; mode_btn = 3'b000; clean_btn = 1'b0; tick_1hz = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    step("reset",        1'b0, 1'b0, 3'b000, 1'b0, 1'b0,  1'b0, 3'd0, 8'd0,   20'd0,     1'b1, 1'b0);
    step("pwr_on",       1'b1, 1'b0, 3'b000, 1'b0, 1'b0,  1'b1, 3'd0, 8'd0,   20'd0,     1'b1, 1'b0);
    step("menu",         1'b0, 1'b1, 3'b000, 1'b0, 1'b0,  1'b1, 3'd0, 8'd0,   20'd0,     1'b1, 1'b0);
    step("speed1",       1'b0, 1'b0, 3'b001, 1'b0, 1'b0,  1'b1, 3'd1, 8'd0,   20'd0,     1'b1, 1'b0);
    ticks(5);
    step("speed1_run",   1'b0, 1'b0, 3'b000, 1'b0, 1'b0,  1'b1, 3'd1, 8'd0,   20'd5,     1'b1, 1'b0);
    step("to_standby",   1'b0, 1'b1, 3'b000, 1'b0, 1'b0,  1'b1, 3'd0, 8'd0,   20'd5,     1'b1, 1'b0);
    step("to_menu",      1'b0, 1'b1, 3'b000, 1'b0, 1'b0,  1'b1, 3'd0, 8'd0,   20'd5,     1'b1, 1'b0);
    step("turbo_in",     1'b0, 1'b0, 3'b100, 1'b0, 1'b0,  1'b1, 3'd3, 8'd60,  20'd5,     1'b0, 1'b0);
    ticks(59);
    step("turbo_cd1",    1'b0, 1'b0, 3'b000, 1'b0, 1'b0,  1'b1, 3'd3, 8'd1,   20'd64,    1'b0, 1'b0);
    step("turbo_exp",    1'b0, 1'b0, 3'b000, 1'b0, 1'b1,  1'b1, 3'd2, 8'd0,   20'd65,    1'b0, 1'b0);
    step("turbo_again",  1'b0, 1'b0, 3'b100, 1'b0, 1'b0,  1'b1, 3'd2, 8'd0,   20'd65,    1'b0, 1'b0);
    step("low_idx",      1'b0, 1'b0, 3'b101, 1'b0, 1'b0,  1'b1, 3'd1, 8'd0,   20'd65,    1'b0, 1'b0);
    step("pwr_off",      1'b1, 1'b0, 3'b000, 1'b0, 1'b0,  1'b0, 3'd0, 8'd0,   20'd65,    1'b0, 1'b0);
    step("pwr_on2",      1'b1, 1'b0, 3'b000, 1'b0, 1'b0,  1'b1, 3'd0, 8'd0,   20'd65,    1'b1, 1'b0);
    step("menu2",        1'b0, 1'b1, 3'b000, 1'b0, 1'b0,  1'b1, 3'd0, 8'd0,   20'd65,    1'b1, 1'b0);
    step("turbo_in2",    1'b0, 1'b0, 3'b100, 1'b0, 1'b0,  1'b1, 3'd3, 8'd60,  20'd65,    1'b0, 1'b0);
    ticks(20);
    step("turbo_cd40",   1'b0, 1'b0, 3'b000, 1'b0, 1'b0,  1'b1, 3'd3, 8'd40,  20'd85,    1'b0, 1'b0);
    step("exit_wait",    1'b0, 1'b1, 3'b000, 1'b0, 1'b0,  1'b1, 3'd2, 8'd60,  20'd85,    1'b0, 1'b0);
    step("exit_ignore",  1'b0, 1'b0, 3'b001, 1'b0, 1'b0,  1'b1, 3'd2, 8'd60,  20'd85,    1'b0, 1'b0);
    ticks(60);
    step("exit_exp",     1'b0, 1'b0, 3'b000, 1'b0, 1'b0,  1'b1, 3'd0, 8'd0,   20'd145,   1'b0, 1'b0);
    step("menu3",        1'b0, 1'b1, 3'b000, 1'b0, 1'b0,  1'b1, 3'd0, 8'd0,   20'd145,   1'b0, 1'b0);
    step("speed1_b",     1'b0, 1'b0, 3'b001, 1'b0, 1'b0,  1'b1, 3'd1, 8'd0,   20'd145,   1'b0, 1'b0);
    ticks(35854);
    step("remind_below", 1'b0, 1'b0, 3'b000, 1'b0, 1'b0,  1'b1, 3'd1, 8'd0,   20'd35999, 1'b0, 1'b0);
    ticks(1);
    step("remind_set",   1'b0, 1'b0, 3'b000, 1'b0, 1'b0,  1'b1, 3'd1, 8'd0,   20'd36000, 1'b0, 1'b1);
    step("standby4",     1'b0, 1'b1, 3'b000, 1'b0, 1'b0,  1'b1, 3'd0, 8'd0,   20'd36000, 1'b0, 1'b1);
    step("menu4",        1'b0, 1'b1, 3'b000, 1'b0, 1'b0,  1'b1, 3'd0, 8'd0,   20'd36000, 1'b0, 1'b1);
    step("clean_in",     1'b0, 1'b0, 3'b000, 1'b1, 1'b0,  1'b1, 3'd4, 8'd180, 20'd36000, 1'b0, 1'b1);
    ticks(179);
    step("clean_cd1",    1'b0, 1'b0, 3'b000, 1'b0, 1'b0,  1'b1, 3'd4, 8'd1,   20'd36000, 1'b0, 1'b1);
    ticks(1);
    step("clean_done",   1'b0, 1'b0, 3'b000, 1'b0, 1'b0,  1'b1, 3'd0, 8'd0,   20'd0,     1'b0, 1'b0);
    step("menu5",        1'b0, 1'b1, 3'b000, 1'b0, 1'b0,  1'b1, 3'd0, 8'd0,   20'd0,     1'b0, 1'b0);
    step("speed1_c",     1'b0, 1'b0, 3'b001, 1'b0, 1'b0,  1'b1, 3'd1, 8'd0,   20'd0,     1'b0, 1'b0);
    ticks(3);
    step("pwr_menu",     1'b1, 1'b1, 3'b000, 1'b0, 1'b0,  1'b0, 3'd0, 8'd0,   20'd3,     1'b0, 1'b0);
    step("pwr_on3",      1'b1, 1'b0, 3'b000, 1'b0, 1'b0,  1'b1, 3'd0, 8'd0,   20'd3,     1'b1, 1'b0);
    step("menu6",        1'b0, 1'b1, 3'b000, 1'b0, 1'b0,  1'b1, 3'd0, 8'd0,   20'd3,     1'b1, 1'b0);
    step("turbo_in3",    1'b0, 1'b0, 3'b100, 1'b0, 1'b0,  1'b1, 3'd3, 8'd60,  20'd3,     1'b0, 1'b0);
    ticks(5);
    step("turbo_mid",    1'b0, 1'b0, 3'b000, 1'b0, 1'b0,  1'b1, 3'd3, 8'd55,  20'd8,     1'b0, 1'b0);

    // Asynchronous reset between clock edges: outputs must clear before the next edge.
    push("async_rst", 1'b0, 3'd0, 8'd0, 20'd0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    pop_check();
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step("post_rst",     1'b0, 1'b0, 3'b000, 1'b0, 1'b0,  1'b0, 3'd0, 8'd0,   20'd0,     1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hood_mode_ctrl.md
Name: hood_mode_ctrl

Overview:
- Parametrised range-hood control FSM. Replaces the fixed 3-speed / self-clean mode decode that currently sits in `top`.
- Turns debounced single-cycle button pulses into the power state, the mode state, a per-mode countdown and a cumulative run-time counter.
- Sits between the button debouncers and the timer/display logic. The display module takes `mode_state`, `countdown` and `run_time` directly.

Parameters:
- N_SPEED, 3, number of fan speeds (≥1). The highest speed is the time-limited turbo.
- TURBO_SEC, 60, turbo run limit in seconds.
- EXIT_SEC, 60, run-down time after leaving turbo via the menu.
- CLEAN_SEC, 180, self-clean duration in seconds.
- REMIND_SEC, 36000, cumulative run time that raises `clean_remind`.
- RUN_W, 20, width of `run_time` (saturating).
- CNT_W, 8, width of `countdown`. Must hold max(TURBO_SEC, EXIT_SEC, CLEAN_SEC).

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- tick_1hz, input, 1, one-cycle pulse once per second.
- power_btn, input, 1, power toggle pulse.
- menu_btn, input, 1, menu pulse.
- mode_btn, input, N_SPEED, one bit per speed. Bit k selects speed k+1.
- clean_btn, input, 1, self-clean request pulse.
- power_on, output, 1, hood powered.
- mode_state, output, $clog2(N_SPEED+2), mode code: 0 standby, 1..N_SPEED speed, N_SPEED+1 clean.
- countdown, output, CNT_W, seconds remaining in a timed state. 0 otherwise.
- run_time, output, RUN_W, cumulative fan-on seconds.
- turbo_avail, output, 1, turbo may still be entered in this power cycle.
- clean_remind, output, 1, high when run_time ≥ REMIND_SEC.

Behaviour:
- All outputs and state are registered. Reset is asynchronous and active-low.
- Reset values: state OFF, power_on 0, mode_state 0, countdown 0, run_time 0, turbo_avail 1, clean_remind 0.
- Button priority within one cycle: power_btn > menu_btn > clean_btn > mode_btn. When several mode_btn bits are set, the lowest index wins. Lower-priority pulses in the same cycle are dropped.
- power_btn in any powered state → OFF next cycle. countdown clears; run_time is retained.
- power_btn in OFF → STANDBY, and turbo_avail is set to 1.

State transitions (all register on the cycle after the button pulse):
- STANDBY:
  - menu_btn → MENU.
- MENU:
  - menu_btn → STANDBY.
  - mode_btn[k] with k < N_SPEED-1 → SPEED(k+1).
  - mode_btn[N_SPEED-1] → TURBO if turbo_avail; otherwise ignored.
  - clean_btn → CLEAN. CLEAN is reachable only from MENU.
- SPEED(s):
  - mode_btn selects another speed directly. Turbo is subject to turbo_avail.
  - menu_btn → STANDBY.
- TURBO:
  - On entry: countdown loads TURBO_SEC and turbo_avail clears.
  - countdown reaching 0 → SPEED(N_SPEED-1), or STANDBY if N_SPEED == 1.
  - menu_btn → EXIT_WAIT, countdown loads EXIT_SEC.
  - mode_btn is ignored.
- EXIT_WAIT:
  - mode_state reports N_SPEED-1 (0 if N_SPEED == 1).
  - All buttons except power are ignored.
  - Expiry → STANDBY.
- CLEAN:
  - countdown loads CLEAN_SEC.
  - All buttons except power are ignored.
  - Expiry → STANDBY and run_time clears to 0 in the same cycle.
  - power_btn aborts to OFF without clearing run_time.

Countdown rules:
- Decrements only on tick_1hz.
- When countdown == 1 and tick_1hz is high, the transition takes effect next cycle with countdown 0.
- A button transition and an expiry in the same cycle resolve by button priority. Power overrides expiry.

run_time rules:
- Increments on tick_1hz while mode_state is in 1..N_SPEED (SPEED, TURBO, EXIT_WAIT).
- Saturates at 2^RUN_W-1.

clean_remind is a registered compare of run_time against REMIND_SEC.

Optional Feature:
- Macro: HOOD_AUTO_OFF_EN.
- With the macro defined:
  - Add parameter IDLE_SEC (default 30).
  - An idle counter runs in STANDBY and MENU. It counts tick_1hz and clears on any button pulse.
  - When the counter reaches IDLE_SEC → OFF.
- Without the macro: no idle counter; STANDBY and MENU persist indefinitely.

Decomposition:
- Package hood_pkg holds:
  - the FSM state enum (OFF, STANDBY, MENU, SPEED, TURBO, EXIT_WAIT, CLEAN);
  - the mode-code constants MODE_STANDBY and a function for MODE_CLEAN(N).
- Sub-module hood_sec_timer: loadable down-counter with load, value, tick and expire outputs. It is instantiated once for countdown, and reused for the idle counter when HOOD_AUTO_OFF_EN is defined.

Test Plan:
- Reset, then power_btn, menu_btn, mode_btn=3'b001 → mode_state 1. After 5 ticks, run_time=5 and countdown=0.
- From MENU, mode_btn=3'b100 → mode_state 3, countdown 60, turbo_avail 0. After 60 ticks → mode_state 2.
- A second turbo request in the same power cycle is ignored.
- In TURBO at countdown 40, menu_btn → EXIT_WAIT, countdown 60, mode_state 2. After 60 ticks → standby.
- Preload run_time ≥ 36000 (clean_remind=1). menu_btn, clean_btn → mode_state 4, countdown 180. After 180 ticks → standby, run_time 0, clean_remind 0.
- power_btn and menu_btn in the same cycle during SPEED → OFF. Assert rst_n low mid-TURBO → all outputs at reset values asynchronously, turbo_avail 1.
